// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus CPU: instruction register, microstep counter and
// opcode decoder. The control word is purely combinational from (ir, step, halted, cf, zf).
module control_sequencer #(
   parameter int unsigned N   = 8,
   parameter int unsigned OPW = 4
) (
   input  logic         clk,
   input  logic         clr_,
   input  logic [N-1:0] bus_in,
   input  logic         cf,
   input  logic         zf,
   output logic [N-1:0] bus,
   output logic         hlt,
   output logic         mi_,
   output logic         ri_,
   output logic         ro_,
   output logic         io_,
   output logic         ii_,
   output logic         ai_,
   output logic         ao_,
   output logic         eo_,
   output logic         su,
   output logic         bi_,
   output logic         oi_,
   output logic         ce,
   output logic         co_,
   output logic         j_,
   output logic         fi_,
   output logic [2:0]   step
);

   localparam int unsigned OpdW = N - OPW;

   typedef enum logic [2:0] {
      StT0 = 3'd0,
      StT1 = 3'd1,
      StT2 = 3'd2,
      StT3 = 3'd3,
      StT4 = 3'd4
   } step_e;

   localparam logic [OPW-1:0] OpNop = OPW'(0);
   localparam logic [OPW-1:0] OpLda = OPW'(1);
   localparam logic [OPW-1:0] OpAdd = OPW'(2);
   localparam logic [OPW-1:0] OpSub = OPW'(3);
   localparam logic [OPW-1:0] OpSta = OPW'(4);
   localparam logic [OPW-1:0] OpLdi = OPW'(5);
   localparam logic [OPW-1:0] OpJmp = OPW'(6);
   localparam logic [OPW-1:0] OpJc  = OPW'(7);
   localparam logic [OPW-1:0] OpJz  = OPW'(8);
   localparam logic [OPW-1:0] OpOut = OPW'(14);
   localparam logic [OPW-1:0] OpHlt = OPW'(15);

   logic [N-1:0]   ir_q, ir_d;
   step_e          step_q, step_d;
   logic           halted_q, halted_d;
   logic [OPW-1:0] opcode;
   logic           last_step;

   assign opcode = ir_q[N-1:N-OpdW-OPW+OpdW];
   assign step   = step_q;

   // Operand is the only thing ever placed on the bus by this block.
   assign bus = io_ ? {N{1'bz}} : {{OPW{1'b0}}, ir_q[OpdW-1:0]};

   // State registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clr_) begin
         ir_q     <= '0;
         step_q   <= StT0;
         halted_q <= 1'b0;
      end else begin
         ir_q     <= ir_d;
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // Microcode decode and next-state: controls default inactive, each step asserts its own set.
   always_comb begin
      hlt       = halted_q;
      mi_       = 1'b1;
      ri_       = 1'b1;
      ro_       = 1'b1;
      io_       = 1'b1;
      ii_       = 1'b1;
      ai_       = 1'b1;
      ao_       = 1'b1;
      eo_       = 1'b1;
      su        = 1'b0;
      bi_       = 1'b1;
      oi_       = 1'b1;
      ce        = 1'b0;
      co_       = 1'b1;
      j_        = 1'b1;
      fi_       = 1'b1;
      last_step = 1'b0;
      ir_d      = ir_q;
      step_d    = step_q;
      halted_d  = halted_q;

      if (!halted_q) begin
         unique case (step_q)
            StT0: begin
               co_ = 1'b0;
               mi_ = 1'b0;
            end
            StT1: begin
               ro_ = 1'b0;
               ii_ = 1'b0;
               ce  = 1'b1;
            end
            StT2: begin
               last_step = !(opcode inside {OpLda, OpAdd, OpSub, OpSta});
               unique case (opcode)
                  OpLda, OpAdd, OpSub, OpSta: begin
                     io_ = 1'b0;
                     mi_ = 1'b0;
                  end
                  OpLdi: begin
                     io_ = 1'b0;
                     ai_ = 1'b0;
                  end
                  OpJmp: begin
                     io_ = 1'b0;
                     j_  = 1'b0;
                  end
                  // Flags only matter in this step; elsewhere cf/zf are ignored.
                  OpJc: begin
                     io_ = !cf;
                     j_  = !cf;
                  end
                  OpJz: begin
                     io_ = !zf;
                     j_  = !zf;
                  end
                  OpOut: begin
                     ao_ = 1'b0;
                     oi_ = 1'b0;
                  end
                  OpHlt: hlt = 1'b1;
                  default: ;  // NOP and undefined opcodes
               endcase
            end
            StT3: begin
               last_step = !(opcode inside {OpAdd, OpSub});
               unique case (opcode)
                  OpLda: begin
                     ro_ = 1'b0;
                     ai_ = 1'b0;
                  end
                  OpAdd, OpSub: begin
                     ro_ = 1'b0;
                     bi_ = 1'b0;
                  end
                  OpSta: begin
                     ao_ = 1'b0;
                     ri_ = 1'b0;
                  end
                  default: ;
               endcase
            end
            StT4: begin
               last_step = 1'b1;
               if (opcode inside {OpAdd, OpSub}) begin
                  eo_ = 1'b0;
                  ai_ = 1'b0;
                  fi_ = 1'b0;
                  su  = (opcode == OpSub);
               end
            end
            default: last_step = 1'b1;
         endcase

         if (step_q == StT1) ir_d = bus_in;
         if (last_step) begin
            step_d = StT0;
            if (step_q == StT2 && opcode == OpHlt) halted_d = 1'b1;
         end else begin
            step_d = step_e'(step_q + 3'd1);
         end
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a behavioural model pushes the expected control word per
// cycle as stimulus is driven; a negedge monitor pops and compares against the DUT.
module tb_control_sequencer;

   localparam logic [15:0] M_HLT = 16'h8000;
   localparam logic [15:0] M_MI  = 16'h4000;
   localparam logic [15:0] M_RI  = 16'h2000;
   localparam logic [15:0] M_RO  = 16'h1000;
   localparam logic [15:0] M_IO  = 16'h0800;
   localparam logic [15:0] M_II  = 16'h0400;
   localparam logic [15:0] M_AI  = 16'h0200;
   localparam logic [15:0] M_AO  = 16'h0100;
   localparam logic [15:0] M_EO  = 16'h0080;
   localparam logic [15:0] M_SU  = 16'h0040;
   localparam logic [15:0] M_BI  = 16'h0020;
   localparam logic [15:0] M_OI  = 16'h0010;
   localparam logic [15:0] M_CE  = 16'h0008;
   localparam logic [15:0] M_CO  = 16'h0004;
   localparam logic [15:0] M_J   = 16'h0002;
   localparam logic [15:0] M_FI  = 16'h0001;
   localparam logic [15:0] INACT = 16'hFFFF & ~(M_HLT | M_SU | M_CE);

   logic       clk = 1'b0;
   logic       clr_;
   logic [7:0] bus_in;
   logic       cf, zf;
   wire  [7:0] bus;
   logic       hlt, mi_, ri_, ro_, io_, ii_, ai_, ao_, eo_, su, bi_, oi_, ce, co_, j_, fi_;
   logic [2:0] step;

   control_sequencer #(.N(8), .OPW(4)) dut (
      .clk(clk), .clr_(clr_), .bus_in(bus_in), .cf(cf), .zf(zf), .bus(bus),
      .hlt(hlt), .mi_(mi_), .ri_(ri_), .ro_(ro_), .io_(io_), .ii_(ii_), .ai_(ai_), .ao_(ao_),
      .eo_(eo_), .su(su), .bi_(bi_), .oi_(oi_), .ce(ce), .co_(co_), .j_(j_), .fi_(fi_),
      .step(step)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [15:0] ctrl;
      logic [2:0]  st;
      logic        chk_bus;
      logic [7:0]  bus;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] m_ir;
   logic [2:0] m_step;
   logic       m_halted;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_ctrl(logic [7:0] ir, logic [2:0] st, logic halted,
                                              logic c, logic z);
      logic [15:0] act;
      act = '0;
      if (halted) act = M_HLT;
      else if (st == 3'd0) act = M_CO | M_MI;
      else if (st == 3'd1) act = M_RO | M_II | M_CE;
      else begin
         case (ir[7:4])
            4'd1: act = (st == 3'd2) ? (M_IO | M_MI) : (st == 3'd3) ? (M_RO | M_AI) : 16'h0;
            4'd2, 4'd3: begin
               if (st == 3'd2) act = M_IO | M_MI;
               if (st == 3'd3) act = M_RO | M_BI;
               if (st == 3'd4) act = M_EO | M_AI | M_FI | ((ir[7:4] == 4'd3) ? M_SU : 16'h0);
            end
            4'd4: act = (st == 3'd2) ? (M_IO | M_MI) : (st == 3'd3) ? (M_AO | M_RI) : 16'h0;
            4'd5: act = (st == 3'd2) ? (M_IO | M_AI) : 16'h0;
            4'd6: act = (st == 3'd2) ? (M_IO | M_J) : 16'h0;
            4'd7: act = (st == 3'd2 && c) ? (M_IO | M_J) : 16'h0;
            4'd8: act = (st == 3'd2 && z) ? (M_IO | M_J) : 16'h0;
            4'd14: act = (st == 3'd2) ? (M_AO | M_OI) : 16'h0;
            4'd15: act = (st == 3'd2) ? M_HLT : 16'h0;
            default: act = '0;
         endcase
      end
      return INACT ^ act;
   endfunction

   function automatic int model_len(logic [3:0] op);
      if (op == 4'd2 || op == 4'd3) return 5;
      if (op == 4'd1 || op == 4'd4) return 4;
      return 3;
   endfunction

   // One clock cycle: drive inputs, push the model's expectation, advance the model.
   task automatic drive_cycle(input string tag, input logic [7:0] din, input logic c,
                              input logic z, input logic clr);
      exp_t e;
      bus_in = din;
      cf     = c;
      zf     = z;
      clr_   = clr;
      e.tag     = tag;
      e.ctrl    = model_ctrl(m_ir, m_step, m_halted, c, z);
      e.st      = m_step;
      e.chk_bus = ((e.ctrl & M_IO) == 16'h0);
      e.bus     = {4'h0, m_ir[3:0]};
      sb.push_back(e);
      if (!clr) begin
         m_ir = 8'h00; m_step = 3'd0; m_halted = 1'b0;
      end else if (!m_halted) begin
         if (m_step == 3'd2 && m_ir[7:4] == 4'hF) begin
            m_halted = 1'b1; m_step = 3'd0;
         end else if (int'(m_step) == model_len(m_ir[7:4]) - 1) begin
            m_step = 3'd0;
         end else begin
            if (m_step == 3'd1) m_ir = din;
            m_step = m_step + 3'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Run one instruction from T0; flags are given for T2 and randomised in every other step.
   task automatic run_instr(input string tag, input logic [7:0] instr, input logic c,
                            input logic z);
      int         n;
      logic [7:0] din;
      logic       cc, zz;
      n = 0;
      do begin
         din = (m_step == 3'd1) ? instr : 8'($urandom_range(0, 255));
         cc  = (m_step == 3'd2) ? c : 1'($urandom);
         zz  = (m_step == 3'd2) ? z : 1'($urandom);
         drive_cycle(tag, din, cc, zz, 1'b1);
         n++;
      end while (m_step != 3'd0 && !m_halted && n < 8);
   endtask

   // Compare each cycle's outputs half a period after the driving edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, ".ctrl"},
               {16'h0, hlt, mi_, ri_, ro_, io_, ii_, ai_, ao_, eo_, su, bi_, oi_, ce, co_, j_, fi_},
               {16'h0, e.ctrl});
         check({e.tag, ".step"}, {29'h0, step}, {29'h0, e.st});
         if (e.chk_bus) check({e.tag, ".bus"}, {24'h0, bus}, {24'h0, e.bus});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_ = 1'b0; bus_in = 8'h00; cf = 1'b0; zf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      m_ir = 8'h00; m_step = 3'd0; m_halted = 1'b0;

      // Clear held for two edges starting in ADD T3.
      drive_cycle("add_t0", 8'h00, 1'b0, 1'b0, 1'b1);
      drive_cycle("add_t1", 8'h2E, 1'b0, 1'b0, 1'b1);
      drive_cycle("add_t2", 8'h00, 1'b0, 1'b0, 1'b1);
      drive_cycle("add_t3_clr", 8'h00, 1'b0, 1'b0, 1'b0);
      drive_cycle("rst_t0", 8'h00, 1'b0, 1'b0, 1'b0);

      run_instr("add", 8'h2E, 1'b0, 1'b0);
      run_instr("sub", 8'h3F, 1'b1, 1'b1);
      run_instr("jc1", 8'h74, 1'b1, 1'b0);
      run_instr("jc0", 8'h74, 1'b0, 1'b1);
      run_instr("jz1", 8'h85, 1'b0, 1'b1);
      run_instr("jz0", 8'h85, 1'b1, 1'b0);
      run_instr("nop", 8'h03, 1'b0, 1'b0);
      run_instr("lda", 8'h1A, 1'b0, 1'b0);
      run_instr("sta", 8'h4B, 1'b0, 1'b0);
      run_instr("jmp", 8'h63, 1'b0, 1'b0);
      run_instr("out", 8'hE9, 1'b0, 1'b0);
      run_instr("undA", 8'hA0, 1'b1, 1'b1);
      run_instr("ldi", 8'h57, 1'b0, 1'b0);
      run_instr("undD", 8'hD9, 1'b1, 1'b1);
      run_instr("hlt", 8'hF0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive_cycle("halted", 8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), 1'b1);
      end
      drive_cycle("halt_clr", 8'h00, 1'b0, 1'b0, 1'b0);
      run_instr("post_clr_ldi", 8'h57, 1'b0, 1'b0);

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU: instruction register, step counter, opcode decoder.
- Drives the control word that the ALU/flag stage consumes (eo_, su, fi_) plus register, memory and PC strobes.
- Consumes registered cf/zf from the flag register for conditional jumps.
- Sits directly upstream of the ALU/flags stage.

Parameters:
N, 8, data/bus width.
OPW, 4, opcode width = instruction register high field; operand = low N-OPW bits.

Ports:
clk  input  1  system clock, rising-edge active.
clr_  input  1  synchronous active-low reset.
bus_in  input  N  bus value; loaded into IR when ii_ is low.
cf  input  1  registered carry flag.
zf  input  1  registered zero flag.
bus  output  N  operand (IR low field, zero-extended) when io_ low; 'bz otherwise.
hlt  output  1  halt, active-high.
mi_  output  1  memory-address-register in.
ri_  output  1  RAM in.
ro_  output  1  RAM out.
io_  output  1  IR operand out.
ii_  output  1  IR in.
ai_  output  1  A in.
ao_  output  1  A out.
eo_  output  1  ALU out.
su  output  1  subtract, active-high.
bi_  output  1  B in.
oi_  output  1  output register in.
ce  output  1  PC count enable, active-high.
co_  output  1  PC out.
j_  output  1  PC load (jump).
fi_  output  1  flag register in.
step  output  3  current microstep (debug).

Behaviour:
- State: ir[N-1:0], step[2:0], halted. Control outputs are combinational from (ir, step, halted, cf, zf); no output register.
- Inactive levels: underscore signals 1, su/ce/hlt 0. Every step word lists only the signals it asserts.
- Reset: clk edge with clr_=0 sets ir=0, step=0, halted=0, so outputs immediately show the T0 word. Reset applies in any step and while halted.
- Fetch, common to all opcodes:
  - T0: co_=0, mi_=0.
  - T1: ro_=0, ii_=0, ce=1. IR loads bus_in at the edge ending T1.
- Execute steps (T2..T4):
  - 0 NOP: T2 empty.
  - 1 LDA: T2 io_,mi_; T3 ro_,ai_.
  - 2 ADD: T2 io_,mi_; T3 ro_,bi_; T4 eo_,ai_,fi_.
  - 3 SUB: as ADD, with su=1 during T4 only.
  - 4 STA: T2 io_,mi_; T3 ao_,ri_.
  - 5 LDI: T2 io_,ai_.
  - 6 JMP: T2 io_,j_.
  - 7 JC: T2 io_,j_ only if cf=1, else empty.
  - 8 JZ: T2 io_,j_ only if zf=1, else empty.
  - 14 OUT: T2 ao_,oi_.
  - 15 HLT: T2 hlt=1.
  - Undefined opcodes (9-13) execute as NOP.
- Step counter:
  - Increments each edge; returns to 0 on the edge after the opcode's last step.
  - Instruction lengths: ADD/SUB 5 cycles; LDA/STA 4; all others 3.
  - step never exceeds 4.
- Flags are sampled combinationally during T2. cf/zf changes in other steps have no effect.
- Halt:
  - At the edge ending HLT T2: halted=1, step=0.
  - While halted: all controls inactive, hlt=1, step and ir frozen, bus 'bz.
  - Only clr_ exits halt.
- Bus output: bus = {{(N-OPW){0}}, ir[N-OPW-1:0]} when io_=0, else high-Z. No other path drives bus.
- The flag register loads on the edge ending ADD/SUB T4 (fi_ low in that step). A JC/JZ issued as the next instruction sees the updated flags.

Test Plan:
1. clr_=0 for 2 edges mid-ADD at T3 → step=0, ir=0, mi_=0, co_=0, all others inactive, bus=Z.
2. Fetch with bus_in=0x2E in T1 → ir=0x2E. T2: io_=0, mi_=0, bus=0x0E. T3: ro_=0, bi_=0. T4: eo_=0, ai_=0, fi_=0, su=0. Next cycle step=0.
3. SUB 0x3F → identical sequence to ADD but su=1 in T4 only. 5 cycles total; step sequence 0,1,2,3,4,0.
4. JC 0x74 with cf=1 → T2: j_=0, io_=0, bus=0x04. Repeat with cf=0 → T2 all inactive, bus=Z. Both take 3 cycles. JZ 0x85 with zf=1 → j_=0, bus=0x05.
5. HLT 0xF0 → T2 hlt=1. Afterwards hlt=1, all controls inactive, step frozen over 10 edges. clr_ pulse → T0 word, hlt=0.
6. Opcode 0xA0 (undefined) and LDI 0x57 → 0xA0: T2 empty, 3 cycles. 0x57: T2 io_=0, ai_=0, bus=0x07.
